bcd_count_ctrl: RTL and testbench
=================================

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port r  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  in  1  begin or resume counting; level sampled each cycle.
REQ-004 SHALL have port stop  in  1  suspend counting; level sampled each cycle.
REQ-005 SHALL have port clr  in  1  synchronous abort: zero the count and return to IDLE.
REQ-006 SHALL have port tick  in  1  count-rate strobe; one increment per qualified tick.
REQ-007 SHALL have port limit  in  16  4-digit BCD terminal value, nibble 3 most significant; sampled only on a start from IDLE.
REQ-008 SHALL have port ec  out  1  count enable driven to the digit chain.
REQ-009 SHALL have port q  out  16  current 4-digit BCD count.
REQ-010 SHALL have port busy  out  1  high in RUN and HOLD.
REQ-011 SHALL have port done  out  1  one-cycle pulse on reaching limit.
REQ-012 SHALL have port err  out  1  one-cycle pulse on a rejected start.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD and DONE.
REQ-014 Command priority SHALL be clr > stop > start.
REQ-015 IDLE + start + valid limit (every nibble <= 9): latch limit into lim_r, load q = 0000, enter RUN next cycle.
REQ-016 IDLE + start + any limit nibble > 9: assert err for exactly one cycle, stay in IDLE, leave q and lim_r unchanged.
REQ-017 ec SHALL be combinational: (state == RUN) and tick and (q != lim_r).
REQ-018 On each edge with ec = 1, q SHALL increment in BCD; a digit at 9 rolls to 0 and carries into the next digit in the same cycle (e.g. 0099 -> 0100).
REQ-019 RUN with q == lim_r: enter DONE on the next edge, tick ignored. Limit 0000 therefore reaches DONE two cycles after the start.
REQ-020 DONE SHALL last exactly one cycle with done = 1, then return to IDLE; q holds the limit value.
REQ-021 RUN + stop: enter HOLD; no increment on that edge even if tick = 1.
REQ-022 HOLD + start (stop low): return to RUN; q and lim_r are kept and limit is not resampled.
REQ-023 HOLD + stop and start together: remain in HOLD.
REQ-024 clr in any state: q = 0000, state = IDLE, done and err forced low next cycle.
REQ-025 start in RUN or DONE SHALL be ignored.
REQ-026 busy SHALL be a registered state decode.
REQ-027 q SHALL never leave the range 0000..lim_r; wrap from 9999 is unreachable and needs no handling.

Reset
REQ-028 While r = 1, asynchronously: state = IDLE, q = 0000, lim_r = 0000, busy = 0, done = 0, err = 0; ec = 0 follows from state.
REQ-029 Reset asserted mid-RUN SHALL abort with no done pulse.
REQ-030 After r deasserts, a start is accepted on the first clock edge.

Structure
REQ-031 Shared package bcd_ctrl_pkg SHALL hold: state enum, DIGITS = 4, BCD_MAX = 9, and a nibble-valid check function.
REQ-032 Sub-module bcd_digit SHALL be a 4-bit decade counter with ports clk, r, en, clr, q[3:0], co; co = en and (q == 9).
REQ-033 bcd_count_ctrl SHALL instantiate bcd_digit four times, chaining each co into the next en, and own the FSM.

Verification
REQ-034 limit = 0012, start pulse, tick every cycle: expect ec high for 12 cycles, q steps 0000..0012 with the 0009 -> 0010 carry, done pulses once, busy falls with DONE.
REQ-035 limit = 00A3 with start: expect err high for 1 cycle, state stays IDLE, q unchanged, ec stays 0.
REQ-036 limit = 0150; stop at q = 0047 with tick high; hold 5 cycles; start: expect q frozen at 0047 through HOLD, then resume to 0150 and done.
REQ-037 limit = 9999, tick every cycle: expect q = 9999 after 9999 ticks, including the 0999 -> 1000 carry, then exactly one done pulse.
REQ-038 clr at q = 0300 while RUN with start and stop both high: expect IDLE, q = 0000, no done; separately, r pulsed mid-RUN: expect all outputs zero asynchronously.
REQ-039 limit = 0000 with start: expect DONE two cycles after start, ec never high, q = 0000.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the 4-digit BCD count controller.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DIGITS  = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  function automatic logic nibble_valid(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

  // A limit is usable only if every digit is a legal BCD value.
  function automatic logic limit_valid(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & nibble_valid(v[4*i +: 4]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter stage; co requests an increment of the next digit.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       r,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       co
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = en && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Start/stop/clear controller around a 4-digit BCD counter that runs up to
// a latched limit and reports completion or a rejected start.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        r,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        tick,
  input  logic [15:0] limit,
  output logic        ec,
  output logic [15:0] q,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_q, state_d;
  logic [15:0] lim_q, lim_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        load;
  logic        inc_en;
  logic        digit_clr;

  logic [DIGITS-1:0] en_chain;
  logic [DIGITS-2:0] co_chain;
  logic              co_unused;

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    load    = 1'b0;
    err_d   = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            if (limit_valid(limit)) begin
              lim_d   = limit;
              load    = 1'b1;
              state_d = ST_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_HOLD;
          end else if (q == lim_q) begin
            state_d = ST_DONE;
          end
        end
        ST_HOLD: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= ST_IDLE;
      lim_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ec = (state_q == ST_RUN) && tick && (q != lim_q);

  // stop and clr win over a tick on the same edge, so the chain sees a gated enable.
  assign inc_en    = ec && !stop && !clr;
  assign digit_clr = clr || load;
  assign en_chain  = {co_chain, inc_en};

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i < DIGITS - 1) begin : g_mid
      bcd_digit u_digit (
        .clk (clk),
        .r   (r),
        .en  (en_chain[i]),
        .clr (digit_clr),
        .q   (q[4*i +: 4]),
        .co  (co_chain[i])
      );
    end else begin : g_top
      // q never exceeds the limit, so the top carry has no consumer.
      bcd_digit u_digit (
        .clk (clk),
        .r   (r),
        .en  (en_chain[i]),
        .clr (digit_clr),
        .q   (q[4*i +: 4]),
        .co  (co_unused)
      );
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed self-checking bench for bcd_count_ctrl.
module tb_bcd_count_ctrl;

  logic        clk;
  logic        r;
  logic        start;
  logic        stop;
  logic        clr;
  logic        tick;
  logic [15:0] limit;
  logic        ec;
  logic [15:0] q;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks;
  int n_errors;

  bcd_count_ctrl dut (
    .clk   (clk),
    .r     (r),
    .start (start),
    .stop  (stop),
    .clr   (clr),
    .tick  (tick),
    .limit (limit),
    .ec    (ec),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // helpers
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] v;
    v[15:12] = 4'((n / 1000) % 10);
    v[11:8]  = 4'((n / 100) % 10);
    v[7:4]   = 4'((n / 10) % 10);
    v[3:0]   = 4'(n % 10);
    return v;
  endfunction

  task automatic start_pulse(input logic [15:0] lim);
    limit = lim;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // expected count sequence for the 0012 run
  logic [15:0] exp_q[$];

  initial begin
    int ec_cnt;
    int edges;
    logic [15:0] e;
    n_checks = 0;
    n_errors = 0;
    r = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; tick = 1'b1; limit = 16'h0000;

    // reset state
    step();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ec", 32'(ec), 32'h0);
    r = 1'b0;

    // limit 0012, tick every cycle
    for (int i = 0; i <= 12; i++) exp_q.push_back(to_bcd(i));
    start_pulse(16'h0012);
    chk("l12_busy", 32'(busy), 32'h1);
    ec_cnt = 0;
    for (int i = 0; i <= 12; i++) begin
      e = exp_q.pop_front();
      chk("l12_q", 32'(q), 32'(e));
      chk("l12_done_low", 32'(done), 32'h0);
      if (ec) ec_cnt++;
      step();
    end
    chk("l12_ec_cycles", 32'(ec_cnt), 32'd12);
    chk("l12_done", 32'(done), 32'h1);
    chk("l12_busy_fall", 32'(busy), 32'h0);
    chk("l12_q_final", 32'(q), 32'h0012);
    step();
    chk("l12_done_once", 32'(done), 32'h0);
    chk("l12_q_hold", 32'(q), 32'h0012);

    // invalid limit
    start_pulse(16'h00A3);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_busy", 32'(busy), 32'h0);
    chk("bad_q", 32'(q), 32'h0012);
    chk("bad_ec", 32'(ec), 32'h0);
    step();
    chk("bad_err_once", 32'(err), 32'h0);
    chk("bad_idle", 32'(busy), 32'h0);

    // stop / hold / resume at 0047 with limit 0150
    start_pulse(16'h0150);
    for (int i = 0; i < 47; i++) step();
    chk("hold_pre_q", 32'(q), 32'h0047);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("hold_q", 32'(q), 32'h0047);
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_ec", 32'(ec), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_frozen", 32'(q), 32'h0047);
    end
    stop = 1'b1; start = 1'b1;
    step();
    chk("hold_both_q", 32'(q), 32'h0047);
    chk("hold_both_ec", 32'(ec), 32'h0);
    stop = 1'b0; limit = 16'h0000;
    step();
    start = 1'b0;
    chk("resume_q", 32'(q), 32'h0047);
    chk("resume_ec", 32'(ec), 32'h1);
    edges = 0;
    while (!done && edges < 300) begin
      step();
      edges++;
    end
    chk("resume_edges", 32'(edges), 32'd104);
    chk("resume_done", 32'(done), 32'h1);
    chk("resume_q_final", 32'(q), 32'h0150);
    step();

    // full range 9999
    start_pulse(16'h9999);
    for (int n = 0; n < 9999; n++) begin
      chk("full_q", 32'(q), 32'(to_bcd(n)));
      if (n == 999) begin
        step();
        chk("full_carry_1000", 32'(q), 32'h1000);
        n++;
        chk("full_q", 32'(q), 32'(to_bcd(n)));
      end
      chk("full_no_done", 32'(done), 32'h0);
      step();
    end
    chk("full_q_max", 32'(q), 32'h9999);
    chk("full_ec_off", 32'(ec), 32'h0);
    step();
    chk("full_done", 32'(done), 32'h1);
    step();
    chk("full_done_once", 32'(done), 32'h0);

    // clr at 0300 with start and stop high
    start_pulse(16'h0500);
    for (int i = 0; i < 300; i++) step();
    chk("clr_pre_q", 32'(q), 32'h0300);
    clr = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    clr = 1'b0; start = 1'b0; stop = 1'b0;
    chk("clr_q", 32'(q), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_done", 32'(done), 32'h0);
    chk("clr_ec", 32'(ec), 32'h0);
    step();
    chk("clr_idle", 32'(busy), 32'h0);
    chk("clr_no_done", 32'(done), 32'h0);

    // asynchronous reset mid-RUN
    start_pulse(16'h0050);
    for (int i = 0; i < 10; i++) step();
    chk("ar_pre_q", 32'(q), 32'h0010);
    #2 r = 1'b1;
    #1;
    chk("ar_q", 32'(q), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_ec", 32'(ec), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
    chk("ar_err", 32'(err), 32'h0);
    step();
    r = 1'b0;

    // limit 0000, start on first edge after reset
    limit = 16'h0000;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("z_busy", 32'(busy), 32'h1);
    chk("z_ec", 32'(ec), 32'h0);
    chk("z_done_early", 32'(done), 32'h0);
    step();
    chk("z_done", 32'(done), 32'h1);
    chk("z_q", 32'(q), 32'h0);
    chk("z_ec_done", 32'(ec), 32'h0);
    step();
    chk("z_done_once", 32'(done), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
